// File: rtl/alu_mul_seq.sv
// Sequential 16x16 multiplier that drives an external combinational ALU.
// Runs unsigned shift-add or signed radix-2 Booth over 16 iterations.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, sign_mode     request and mode; both sampled only in IDLE
//   mcand, mplier        operands, captured on an accepted start
//   busy, done, product  status, one-cycle done pulse, 32-bit result
//   alu_A .. alu_sign    operand and control outputs to the ALU
//   alu_Out/Cout/Ofl     result and flags returned by the ALU

module alu_mul_seq #(
    parameter int WIDTH = 16,
    parameter int ITERS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sign_mode,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   alu_A,
    output logic [WIDTH-1:0]   alu_B,
    output logic               alu_Cin,
    output logic [2:0]         alu_Op,
    output logic               alu_invA,
    output logic               alu_invB,
    output logic               alu_sign,
    input  logic [WIDTH-1:0]   alu_Out,
    input  logic               alu_Cout,
    input  logic               alu_Ofl
);

    localparam int CW = $clog2(ITERS);
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;
    logic [WIDTH-1:0] m;
    logic             q;
    logic [CW-1:0]    cnt;
    logic             smode;
    logic             done_q;

    logic             do_add;
    logic             do_sub;
    logic [WIDTH-1:0] sum;
    logic             s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operation select. Booth pair {P_lo[0], q}: 01 adds, 10 subtracts.
    always_comb begin
        do_add = 1'b0;
        do_sub = 1'b0;
        if (state == RUN) begin
            if (smode) begin
                do_add = ~p_lo[0] & q;
                do_sub = p_lo[0] & ~q;
            end else begin
                do_add = p_lo[0];
            end
        end
    end

    // Shift-in bit: carry for unsigned, true 17-bit sign for signed.
    // The Ofl term keeps the sign right when M = 0x8000 overflows.
    always_comb begin
        sum = p_hi;
        s   = smode & p_hi[WIDTH-1];
        if (do_add | do_sub) begin
            sum = alu_Out;
            if (smode) begin
                s = alu_Out[WIDTH-1] ^ alu_Ofl;
            end else begin
                s = alu_Cout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_hi   <= '0;
            p_lo   <= '0;
            m      <= '0;
            q      <= 1'b0;
            cnt    <= '0;
            smode  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == DONE);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        m     <= mcand;
                        p_hi  <= '0;
                        p_lo  <= mplier;
                        q     <= 1'b0;
                        cnt   <= '0;
                        smode <= sign_mode;
                    end
                end
                RUN: begin
                    p_hi <= {s, sum[WIDTH-1:1]};
                    p_lo <= {sum[0], p_lo[WIDTH-1:1]};
                    q    <= p_lo[0];
                    cnt  <= cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign done     = done_q;
    assign product  = {p_hi, p_lo};
    assign alu_A    = p_hi;
    assign alu_B    = m;
    assign alu_Cin  = do_sub;
    assign alu_invB = do_sub;
    assign alu_Op   = 3'b100;
    assign alu_invA = 1'b0;
    assign alu_sign = smode;

endmodule
